str_fifo: RTL and testbench
===========================

# str_fifo

Synchronous stream FIFO that sits directly upstream of the stream gearbox and decouples producer timing from gearbox/consumer back-pressure. It carries a data word plus an end-of-packet `last` flag per entry over valid/ready handshakes on both sides, presenting first-word-fall-through output. It reports word occupancy and the number of complete packets stored, so control logic can gate downstream transfers on whole packets.

## Interface
- `DATA_WIDTH`, default 24: data bits per word; matches the gearbox up-side width.
- `DEPTH_LOG2`, default 4: log2 of entry count. Depth `DEPTH = 2**DEPTH_LOG2`.

Ports:
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `up_data`  in  DATA_WIDTH: write word.
- `up_last`  in  1: write word is the last of its packet.
- `up_val`  in  1: write word valid.
- `up_rdy`  out  1: FIFO can accept a word.
- `dn_data`  out  DATA_WIDTH: head word.
- `dn_last`  out  1: `last` flag of the head word.
- `dn_val`  out  1: head word valid.
- `dn_rdy`  in  1: consumer accepts head word.
- `level`  out  DEPTH_LOG2+1: words stored, 0..DEPTH.
- `pkt_cnt`  out  DEPTH_LOG2+1: words stored with `last`=1, 0..DEPTH.

## Operation
- Storage: DEPTH entries of DATA_WIDTH+1 bits ({last, data}); memory contents are not reset.
- Pointers: `wr_ptr` and `rd_ptr` are DEPTH_LOG2+1 bits wide (extra wrap bit). Index = low DEPTH_LOG2 bits. Empty when pointers are equal; full when the low bits are equal and the MSBs differ. Pointers wrap modulo 2·DEPTH.
- Push = `up_val & up_rdy`: write {up_last, up_data} at `wr_ptr`, increment `wr_ptr`.
- Pop = `dn_val & dn_rdy`: increment `rd_ptr`.
- `up_rdy = !full & !rst`. It is decoded from registers only, with no combinational path from `dn_rdy`. A pop in the same cycle as full does not enable a push.
- `dn_val = !empty`.
- `dn_data`/`dn_last` = entry at `rd_ptr` when not empty, otherwise 0.
- `level` is a register:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- `pkt_cnt` is a register:
  - push with `up_last`=1: +1.
  - pop with `dn_last`=1: −1.
  - both in the same cycle: unchanged.
- No overflow or underflow is possible, because handshakes are gated by full and empty.
- Protocol rules:
  - Upstream must hold `up_data`/`up_last` stable while `up_val & !up_rdy`.
  - The FIFO holds its head stable while `dn_val & !dn_rdy`.
  - Once asserted, `dn_val` does not drop until a pop occurs.

## Timing
- Reset is asynchronous. While `rst`=1, and immediately on assertion:
  - Pointers, `level` and `pkt_cnt` are 0.
  - `dn_val`=0, `dn_data`=0, `dn_last`=0.
  - `up_rdy`=0.
- First cycle after `rst` deasserts: `up_rdy`=1.
- Reset mid-stream discards all stored words. A handshake in the cycle reset asserts is lost.
- Write-to-read latency is 1 cycle. A word pushed at edge N is visible on `dn_*` with `dn_val`=1 after edge N, including when the FIFO was empty. Words are never output combinationally from `up_data`.
- Throughput is one push and one pop per cycle sustained, at any level 1..DEPTH−1.
- Full: after the DEPTH-th push, `up_rdy` falls after that edge. It rises after the edge of the next pop.
- Empty: after the last pop, `dn_val` falls after that edge.
- `level` and `pkt_cnt` update on the same edge as the handshake.

## Test plan
- **Reset:** push 5 words, then assert `rst` between edges → `dn_val`, `up_rdy`, `level`, `pkt_cnt`, `dn_data` go to 0 without a clock edge. After release, `dn_val` stays 0 until a new push.
- **Fill:**
  - Stimulus: `dn_rdy`=0, `up_val`=1, data 0x000001,0x000002,… .
  - Exactly 16 words are accepted, `level`=16, and `up_rdy`=0.
  - Word 0x000011 is held, not lost.
  - Raising `dn_rdy` pops 0x000001 first and `up_rdy` returns 1 the next cycle.
- **Ordering across wrap:** stream 256 words 0x000001..0x000100 with `dn_rdy` toggling 1,1,0,1,0,0 repeating → output sequence is identical and gap-free, and `level` never exceeds 16.
- **Simultaneous push/pop:**
  - Start at `level`=8 and hold `up_val`=`dn_rdy`=1 for 10 cycles.
  - `level` stays 8 and output is in push order.
  - At `level`=0 with both asserted, only the push occurs; `level`=1 next cycle.
- **Packets:**
  - Push two packets of 3 words with `last` on words 3 and 6 → `pkt_cnt`=2, `level`=6.
  - Pop 3 words → `pkt_cnt`=1, with `dn_last`=1 exactly on the 3rd.
  - Pushing a `last` word while popping a `last` word leaves `pkt_cnt` unchanged.
- **Empty pass-through:** with the FIFO empty and `dn_rdy`=1, push 0xABCDEF at edge N → `dn_val`=1 and `dn_data`=0xABCDEF after edge N; popped at edge N+1; `dn_val`=0 after N+1.

Source files
------------

// File: rtl/str_fifo_if.sv
// Handshake bundle for the stream FIFO: write side (up_*) and read side (dn_*).
// The master drives words in and the read-side ready. The slave is the FIFO itself.
interface str_fifo_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] up_data;
  logic                  up_last;
  logic                  up_val;
  logic                  up_rdy;
  logic [DATA_WIDTH-1:0] dn_data;
  logic                  dn_last;
  logic                  dn_val;
  logic                  dn_rdy;

  modport master (
    output up_data, up_last, up_val, dn_rdy,
    input  up_rdy, dn_data, dn_last, dn_val
  );

  modport slave (
    input  up_data, up_last, up_val, dn_rdy,
    output up_rdy, dn_data, dn_last, dn_val
  );
endinterface

// File: rtl/str_fifo.sv
// First-word-fall-through stream FIFO carrying {last, data} per entry.
// Tracks word occupancy and the count of stored end-of-packet words.
module str_fifo #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  str_fifo_if.slave           bus,
  output logic [DEPTH_LOG2:0] level,
  output logic [DEPTH_LOG2:0] pkt_cnt
);
  localparam int                  DEPTH   = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DATA_WIDTH:0]   head;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  push_last;
  logic                  pop_last;

  // The extra pointer MSB tells full apart from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                 (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);

  assign head        = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign bus.up_rdy  = !full && !rst;
  assign bus.dn_val  = !empty;
  assign bus.dn_data = empty ? '0 : head[DATA_WIDTH-1:0];
  assign bus.dn_last = empty ? 1'b0 : head[DATA_WIDTH];

  assign push      = bus.up_val && bus.up_rdy;
  assign pop       = bus.dn_val && bus.dn_rdy;
  assign push_last = push && bus.up_last;
  assign pop_last  = pop && bus.dn_last;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {bus.up_last, bus.up_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + CNT_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CNT_ONE;
      end
      if (push && !pop) begin
        level <= level + CNT_ONE;
      end else if (pop && !push) begin
        level <= level - CNT_ONE;
      end
      if (push_last && !pop_last) begin
        pkt_cnt <= pkt_cnt + CNT_ONE;
      end else if (pop_last && !push_last) begin
        pkt_cnt <= pkt_cnt - CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_str_fifo.sv
// Directed testbench for str_fifo: reset, fill, wrap ordering, simultaneous
// push/pop, packet counting and empty pass-through.
module tb_str_fifo;
  logic       clk;
  logic       rst;
  logic [4:0] level;
  logic [4:0] pkt_cnt;
  int         checks;
  int         failures;

  str_fifo_if #(.DATA_WIDTH(24)) bus ();

  str_fifo #(.DATA_WIDTH(24), .DEPTH_LOG2(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .level   (level),
    .pkt_cnt (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.up_val = 1'b0; bus.up_last = 1'b0; bus.up_data = '0; bus.dn_rdy = 1'b0;
    #1;
    checks++;
    if (bus.up_rdy !== 1'b0 || bus.dn_val !== 1'b0 || level !== 5'd0) begin
      failures++;
      $display("FAIL reset_init up_rdy=%b dn_val=%b level=%0d exp 0/0/0", bus.up_rdy, bus.dn_val, level);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.up_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_up_rdy got=%b exp=1", bus.up_rdy);
    end
    bus.up_val = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.up_data = 24'(i);
      bus.up_last = (i == 5);
      tick();
    end
    bus.up_val = 1'b0;
    bus.up_last = 1'b0;
    checks++;
    if (level !== 5'd5 || pkt_cnt !== 5'd1 || bus.dn_data !== 24'd1) begin
      failures++;
      $display("FAIL reset_prefill level=%0d pkt=%0d data=%h exp 5/1/000001", level, pkt_cnt, bus.dn_data);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dn_val !== 1'b0 || bus.up_rdy !== 1'b0 || level !== 5'd0 ||
        pkt_cnt !== 5'd0 || bus.dn_data !== 24'd0 || bus.dn_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_async dn_val=%b up_rdy=%b level=%0d pkt=%0d data=%h last=%b exp all 0",
               bus.dn_val, bus.up_rdy, level, pkt_cnt, bus.dn_data, bus.dn_last);
    end
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.dn_val !== 1'b0 || level !== 5'd0) begin
        failures++;
        $display("FAIL reset_after_release cyc=%0d dn_val=%b level=%0d exp 0/0", i, bus.dn_val, level);
      end
    end
  endtask

  task automatic test_fill();
    int  acc;
    int  d;
    int  exp_d;
    bit  hs;
    acc = 0;
    d = 1;
    bus.dn_rdy = 1'b0;
    bus.up_val = 1'b1;
    bus.up_last = 1'b0;
    bus.up_data = 24'(d);
    for (int i = 0; i < 20; i++) begin
      hs = bus.up_val && bus.up_rdy;
      tick();
      if (hs) begin
        acc++;
        d++;
        bus.up_data = 24'(d);
      end
    end
    checks++;
    if (acc != 16 || level !== 5'd16 || bus.up_rdy !== 1'b0) begin
      failures++;
      $display("FAIL fill_full accepted=%0d level=%0d up_rdy=%b exp 16/16/0", acc, level, bus.up_rdy);
    end
    checks++;
    if (bus.dn_data !== 24'h000001 || bus.dn_val !== 1'b1) begin
      failures++;
      $display("FAIL fill_head data=%h val=%b exp 000001/1", bus.dn_data, bus.dn_val);
    end
    bus.dn_rdy = 1'b1;
    tick();
    checks++;
    if (bus.up_rdy !== 1'b1 || level !== 5'd15 || bus.dn_data !== 24'h000002) begin
      failures++;
      $display("FAIL fill_first_pop up_rdy=%b level=%0d data=%h exp 1/15/000002", bus.up_rdy, level, bus.dn_data);
    end
    tick();
    bus.up_val = 1'b0;
    checks++;
    if (level !== 5'd15) begin
      failures++;
      $display("FAIL fill_pushpop_level got=%0d exp=15", level);
    end
    exp_d = 3;
    for (int i = 0; i < 40 && exp_d <= 24'h11; i++) begin
      if (bus.dn_val && bus.dn_rdy) begin
        checks++;
        if (bus.dn_data !== 24'(exp_d)) begin
          failures++;
          $display("FAIL fill_drain got=%h exp=%h", bus.dn_data, 24'(exp_d));
        end
        exp_d++;
      end
      tick();
    end
    checks++;
    if (exp_d != 24'h12 || level !== 5'd0 || bus.dn_val !== 1'b0) begin
      failures++;
      $display("FAIL fill_drain_end next=%h level=%0d dn_val=%b exp 000012/0/0", 24'(exp_d), level, bus.dn_val);
    end
  endtask

  task automatic test_wrap();
    bit pat [6];
    int wr_next;
    int rd_exp;
    int mdl_level;
    int cyc;
    bit push;
    bit pop;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    wr_next = 1;
    rd_exp = 1;
    mdl_level = 0;
    cyc = 0;
    bus.up_val = 1'b1;
    bus.up_last = 1'b0;
    bus.up_data = 24'(wr_next);
    while (rd_exp <= 256 && cyc < 2000) begin
      bus.dn_rdy = pat[cyc % 6];
      #0;
      push = bus.up_val && bus.up_rdy;
      pop  = bus.dn_val && bus.dn_rdy;
      if (pop) begin
        checks++;
        if (bus.dn_data !== 24'(rd_exp)) begin
          failures++;
          $display("FAIL wrap_order got=%h exp=%h", bus.dn_data, 24'(rd_exp));
        end
        rd_exp++;
      end
      tick();
      cyc++;
      if (push) begin
        wr_next++;
        if (wr_next > 256) bus.up_val = 1'b0;
        else bus.up_data = 24'(wr_next);
      end
      mdl_level += (push ? 1 : 0) - (pop ? 1 : 0);
      if (int'(level) != mdl_level || level > 5'd16) begin
        checks++;
        failures++;
        $display("FAIL wrap_level cyc=%0d got=%0d exp=%0d", cyc, level, mdl_level);
      end
    end
    checks++;
    if (rd_exp != 257 || level !== 5'd0) begin
      failures++;
      $display("FAIL wrap_done popped_to=%0d level=%0d exp 257/0", rd_exp, level);
    end
    bus.dn_rdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.up_val = 1'b1;
    bus.up_last = 1'b0;
    bus.dn_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.up_data = 24'(32'h100 + i);
      tick();
    end
    checks++;
    if (level !== 5'd8) begin
      failures++;
      $display("FAIL b2b_start_level got=%0d exp=8", level);
    end
    bus.dn_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.up_data = 24'(32'h108 + k);
      checks++;
      if (bus.dn_data !== 24'(32'h100 + k)) begin
        failures++;
        $display("FAIL b2b_order got=%h exp=%h", bus.dn_data, 24'(32'h100 + k));
      end
      tick();
      checks++;
      if (level !== 5'd8) begin
        failures++;
        $display("FAIL b2b_level got=%0d exp=8", level);
      end
    end
    bus.up_val = 1'b0;
    for (int k = 10; k < 18; k++) begin
      checks++;
      if (bus.dn_data !== 24'(32'h100 + k) || bus.dn_val !== 1'b1) begin
        failures++;
        $display("FAIL b2b_drain got=%h exp=%h", bus.dn_data, 24'(32'h100 + k));
      end
      tick();
    end
    checks++;
    if (level !== 5'd0 || bus.dn_val !== 1'b0) begin
      failures++;
      $display("FAIL b2b_empty level=%0d dn_val=%b exp 0/0", level, bus.dn_val);
    end
    bus.up_val = 1'b1;
    bus.up_data = 24'h000555;
    tick();
    bus.up_val = 1'b0;
    checks++;
    if (level !== 5'd1 || bus.dn_val !== 1'b1 || bus.dn_data !== 24'h000555) begin
      failures++;
      $display("FAIL b2b_empty_both level=%0d val=%b data=%h exp 1/1/000555", level, bus.dn_val, bus.dn_data);
    end
    tick();
    checks++;
    if (level !== 5'd0) begin
      failures++;
      $display("FAIL b2b_final_level got=%0d exp=0", level);
    end
    bus.dn_rdy = 1'b0;
  endtask

  task automatic test_packets();
    bus.dn_rdy = 1'b0;
    bus.up_val = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      bus.up_data = 24'(32'h200 + i);
      bus.up_last = (i == 3 || i == 6);
      tick();
    end
    bus.up_val = 1'b0;
    bus.up_last = 1'b0;
    checks++;
    if (pkt_cnt !== 5'd2 || level !== 5'd6) begin
      failures++;
      $display("FAIL pkt_fill pkt=%0d level=%0d exp 2/6", pkt_cnt, level);
    end
    bus.dn_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.dn_last !== (k == 2)) begin
        failures++;
        $display("FAIL pkt_last_flag word=%0d got=%b exp=%b", k, bus.dn_last, (k == 2));
      end
      tick();
    end
    checks++;
    if (pkt_cnt !== 5'd1 || level !== 5'd3) begin
      failures++;
      $display("FAIL pkt_pop3 pkt=%0d level=%0d exp 1/3", pkt_cnt, level);
    end
    tick();
    tick();
    checks++;
    if (bus.dn_last !== 1'b1 || bus.dn_data !== 24'h000206 || pkt_cnt !== 5'd1) begin
      failures++;
      $display("FAIL pkt_head6 last=%b data=%h pkt=%0d exp 1/000206/1", bus.dn_last, bus.dn_data, pkt_cnt);
    end
    bus.up_val = 1'b1;
    bus.up_last = 1'b1;
    bus.up_data = 24'h000207;
    tick();
    bus.up_val = 1'b0;
    bus.up_last = 1'b0;
    checks++;
    if (pkt_cnt !== 5'd1 || level !== 5'd1) begin
      failures++;
      $display("FAIL pkt_simul pkt=%0d level=%0d exp 1/1", pkt_cnt, level);
    end
    tick();
    checks++;
    if (pkt_cnt !== 5'd0 || level !== 5'd0) begin
      failures++;
      $display("FAIL pkt_drain pkt=%0d level=%0d exp 0/0", pkt_cnt, level);
    end
    bus.dn_rdy = 1'b0;
  endtask

  task automatic test_passthrough();
    bus.dn_rdy = 1'b1;
    bus.up_val = 1'b1;
    bus.up_last = 1'b0;
    bus.up_data = 24'hABCDEF;
    #0;
    checks++;
    if (bus.dn_val !== 1'b0 || bus.dn_data !== 24'd0) begin
      failures++;
      $display("FAIL pass_pre val=%b data=%h exp 0/000000", bus.dn_val, bus.dn_data);
    end
    tick();
    bus.up_val = 1'b0;
    checks++;
    if (bus.dn_val !== 1'b1 || bus.dn_data !== 24'hABCDEF) begin
      failures++;
      $display("FAIL pass_visible val=%b data=%h exp 1/abcdef", bus.dn_val, bus.dn_data);
    end
    tick();
    checks++;
    if (bus.dn_val !== 1'b0 || bus.dn_data !== 24'd0 || level !== 5'd0) begin
      failures++;
      $display("FAIL pass_popped val=%b data=%h level=%0d exp 0/000000/0", bus.dn_val, bus.dn_data, level);
    end
    bus.dn_rdy = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fill();
    test_wrap();
    test_back_to_back();
    test_packets();
    test_passthrough();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
